// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single synchronous-read byte memory.
// Supports round-robin or fixed priority, plus bounded bus locking for atomic sequences.
module mem_arbiter #(
  parameter int LOCK_MAX   = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic        p0_lock,
  input  logic [15:0] p0_addr,
  input  logic [7:0]  p0_wdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic        p1_lock,
  input  logic [15:0] p1_addr,
  input  logic [7:0]  p1_wdata,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_rvalid,
  output logic        p1_rvalid,
  output logic [7:0]  p0_rdata,
  output logic [7:0]  p1_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [CNT_W-1:0] cnt_next;
  logic             last_q, last_d;  // port that won most recently
  logic [1:0]       bar_q, bar_d;    // port barred after a forced release
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;
  logic             elig0, elig1;
  logic             win_port, win_lock;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    last_d     = last_q;
    bar_d      = bar_q;
    p0_gnt     = 1'b0;
    p1_gnt     = 1'b0;
    elig0      = 1'b0;
    elig1      = 1'b0;
    win_port   = 1'b0;
    win_lock   = 1'b0;
    cnt_next   = '0;

    if (!reset) begin
      case (state_q)
        IDLE: begin
          // A barred port yields only while the other port is actually asking.
          elig0 = p0_req && !(bar_q[0] && p1_req);
          elig1 = p1_req && !(bar_q[1] && p0_req);
          if (elig0 && elig1) begin
            if ((FIXED_PRIO != 0) || last_q) begin
              p0_gnt = 1'b1;
            end else begin
              p1_gnt = 1'b1;
            end
          end else begin
            p0_gnt = elig0;
            p1_gnt = elig1;
          end
        end
        OWN0:    p0_gnt = p0_req;
        OWN1:    p1_gnt = p1_req;
        default: ;
      endcase

      if (p1_gnt || !p1_req) bar_d[0] = 1'b0;
      if (p0_gnt || !p0_req) bar_d[1] = 1'b0;

      if (p0_gnt || p1_gnt) begin
        win_port = p1_gnt;
        win_lock = p1_gnt ? p1_lock : p0_lock;
        cnt_next = (state_q == IDLE) ? CNT_W'(1) : lock_cnt_q + 1'b1;
        last_d   = win_port;
        if (win_lock && (cnt_next < CNT_W'(LOCK_MAX))) begin
          state_d    = win_port ? OWN1 : OWN0;
          lock_cnt_d = cnt_next;
        end else begin
          state_d    = IDLE;
          lock_cnt_d = '0;
          if (win_lock) bar_d[win_port] = 1'b1;
        end
      end
    end

    rvalid0_d = p0_gnt && !p0_we;
    rvalid1_d = p1_gnt && !p1_we;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (p0_gnt) begin
      mem_we    = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (p1_gnt) begin
      mem_we    = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  assign mem_en = p0_gnt | p1_gnt;

  // Masking with reset kills a read response that would land in a reset cycle.
  assign p0_rvalid = rvalid0_q & ~reset;
  assign p1_rvalid = rvalid1_q & ~reset;
  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      lock_cnt_q <= '0;
      last_q     <= 1'b1;
      bar_q      <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      last_q     <= last_d;
      bar_q      <= bar_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin instance backed by a byte memory model,
// and a fixed-priority instance on the same request inputs.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0, p0_lock = 1'b0;
  logic [15:0] p0_addr = '0;
  logic [7:0]  p0_wdata = '0;
  logic        p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
  logic [15:0] p1_addr = '0;
  logic [7:0]  p1_wdata = '0;
  logic [7:0]  mem_rdata;

  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [7:0]  p0_rdata, p1_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;

  logic        fp_p0_gnt, fp_p1_gnt, fp_p0_rvalid, fp_p1_rvalid;
  logic [7:0]  fp_p0_rdata, fp_p1_rdata;
  logic        fp_mem_en, fp_mem_we;
  logic [15:0] fp_mem_addr;
  logic [7:0]  fp_mem_wdata;

  mem_arbiter #(.LOCK_MAX(8), .FIXED_PRIO(0)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.LOCK_MAX(8), .FIXED_PRIO(1)) dut_fp (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(fp_p0_gnt), .p1_gnt(fp_p1_gnt), .p0_rvalid(fp_p0_rvalid), .p1_rvalid(fp_p1_rvalid),
    .p0_rdata(fp_p0_rdata), .p1_rdata(fp_p1_rdata),
    .mem_en(fp_mem_en), .mem_we(fp_mem_we), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         port;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       sb[$];
  exp_t       me;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  logic [7:0] mem [0:65535];
  logic [7:0] shadow [int];
  logic       got_v, other_v;
  logic [7:0] got_d;

  // Memory model: synchronous read, data one cycle after a read strobe.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  function automatic logic [7:0] exp_byte(input logic [15:0] a);
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    if (a == 16'h1234) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic push_read(input bit port, input logic [15:0] a);
    exp_t e;
    e.port = port;
    e.data = exp_byte(a);
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    p0_req = 1'b0; p0_we = 1'b0; p0_lock = 1'b0;
    p1_req = 1'b0; p1_we = 1'b0; p1_lock = 1'b0;
  endtask

  // Per-cycle monitor: grant exclusivity, strobe, and scoreboard of read responses.
  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      if (p0_gnt && p1_gnt) begin
        errors++;
        $display("FAIL gnt_onehot: p0_gnt=%b p1_gnt=%b, required at most one high", p0_gnt, p1_gnt);
      end
      checks++;
      if (fp_p0_gnt && fp_p1_gnt) begin
        errors++;
        $display("FAIL fp_gnt_onehot: p0_gnt=%b p1_gnt=%b, required at most one high", fp_p0_gnt, fp_p1_gnt);
      end
      checks++;
      if (mem_en !== (p0_gnt | p1_gnt)) begin
        errors++;
        $display("FAIL mem_en: got %b, required %b", mem_en, p0_gnt | p1_gnt);
      end
      checks++;
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        me      = sb.pop_front();
        got_v   = me.port ? p1_rvalid : p0_rvalid;
        other_v = me.port ? p0_rvalid : p1_rvalid;
        got_d   = me.port ? p1_rdata : p0_rdata;
        if (got_v !== 1'b1 || other_v !== 1'b0 || got_d !== me.data) begin
          errors++;
          $display("FAIL read_resp p%0d: rvalid=%b other_rvalid=%b rdata=%h, required 1/0/%h",
                   me.port, got_v, other_v, got_d, me.data);
        end
      end else if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL spurious_rvalid: p0_rvalid=%b p1_rvalid=%b, required 0/0", p0_rvalid, p1_rvalid);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    p0_req = 1'b1; p1_req = 1'b1; p0_addr = 16'h0010; p1_addr = 16'h0020;
    repeat (2) step();
    mon_en = 1'b1;
    @(negedge clock);
    checks++;
    if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt: gnt=%b%b mem_en=%b, required 00 0", p0_gnt, p1_gnt, mem_en);
    end
    checks++;
    if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0 || fp_p0_rvalid !== 1'b0 || fp_p1_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rvalid: %b%b%b%b, required 0000", p0_rvalid, p1_rvalid, fp_p0_rvalid, fp_p1_rvalid);
    end
    checks++;
    if (fp_p0_gnt !== 1'b0 || fp_p1_gnt !== 1'b0 || fp_mem_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_fp_gnt: gnt=%b%b mem_en=%b, required 00 0", fp_p0_gnt, fp_p1_gnt, fp_mem_en);
    end
    step();
    reset = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_lone_read();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h1234;
    @(negedge clock);
    checks++;
    if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0 || mem_addr !== 16'h1234 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL lone_read_gnt: gnt=%b%b addr=%h we=%b, required 10 1234 0", p0_gnt, p1_gnt, mem_addr, mem_we);
    end
    push_read(1'b0, 16'h1234);
    step();
    p0_req = 1'b0;
    @(negedge clock);
    checks++;
    if (p0_rvalid !== 1'b1 || p0_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL lone_read_data: rvalid=%b rdata=%h, required 1 a5", p0_rvalid, p0_rdata);
    end
    checks++;
    if (p1_rdata !== 8'hA5 || fp_p0_rdata !== 8'hA5 || fp_p1_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL rdata_fanout: %h %h %h, required a5", p1_rdata, fp_p0_rdata, fp_p1_rdata);
    end
    step();
  endtask

  task automatic test_write_read();
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 16'h0042; p1_wdata = 8'h3C;
    @(negedge clock);
    checks++;
    if (p1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0042 || mem_wdata !== 8'h3C) begin
      errors++;
      $display("FAIL write_gnt: gnt=%b we=%b addr=%h wdata=%h, required 1 1 0042 3c", p1_gnt, mem_we, mem_addr, mem_wdata);
    end
    shadow[int'(16'h0042)] = 8'h3C;
    step();
    p1_we = 1'b0;
    @(negedge clock);
    checks++;
    if (p1_rvalid !== 1'b0 || p1_gnt !== 1'b1) begin
      errors++;
      $display("FAIL write_no_rvalid: rvalid=%b gnt=%b, required 0 1", p1_rvalid, p1_gnt);
    end
    push_read(1'b1, 16'h0042);
    step();
    p1_req = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    p0_req = 1'b1; p1_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      p0_addr = 16'h0100 + 16'(k);
      p1_addr = 16'h0200 + 16'(k);
      @(negedge clock);
      checks++;
      if (p0_gnt !== (k % 2 == 0) || p1_gnt !== (k % 2 == 1) ||
          mem_addr !== ((k % 2 == 0) ? p0_addr : p1_addr)) begin
        errors++;
        $display("FAIL round_robin[%0d]: gnt=%b%b addr=%h, required p%0d", k, p0_gnt, p1_gnt, mem_addr, k % 2);
      end
      if (p0_gnt) push_read(1'b0, p0_addr);
      if (p1_gnt) push_read(1'b1, p1_addr);
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_lock();
    bit r1 [6] = '{1, 1, 0, 1, 1, 0};
    bit l1 [6] = '{1, 1, 0, 1, 0, 0};
    bit g0 [6] = '{0, 0, 0, 0, 0, 1};
    bit g1 [6] = '{1, 1, 0, 1, 1, 0};
    p0_req = 1'b1; p0_addr = 16'h0300;
    @(negedge clock);
    checks++;
    if (p0_gnt !== 1'b1) begin
      errors++;
      $display("FAIL lock_setup: p0_gnt=%b, required 1", p0_gnt);
    end
    if (p0_gnt) push_read(1'b0, p0_addr);
    step();
    p0_addr = 16'h0310;
    for (int k = 0; k < 6; k++) begin
      p1_req  = r1[k];
      p1_lock = l1[k];
      p1_addr = 16'h0320 + 16'(k);
      @(negedge clock);
      checks++;
      if (p0_gnt !== g0[k] || p1_gnt !== g1[k]) begin
        errors++;
        $display("FAIL lock[%0d]: gnt=%b%b, required %b%b", k, p0_gnt, p1_gnt, g0[k], g1[k]);
      end
      if (p0_gnt) push_read(1'b0, p0_addr);
      if (p1_gnt) push_read(1'b1, p1_addr);
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_forced_release();
    for (int k = 0; k < 10; k++) begin
      p0_req  = 1'b1;
      p0_lock = (k < 9);
      p0_addr = 16'h0400 + 16'(k);
      p1_req  = (k >= 1);
      p1_addr = 16'h0500 + 16'(k);
      @(negedge clock);
      checks++;
      if (p0_gnt !== (k != 8) || p1_gnt !== (k == 8)) begin
        errors++;
        $display("FAIL forced_release[%0d]: gnt=%b%b, required %b%b", k, p0_gnt, p1_gnt, k != 8, k == 8);
      end
      if (p0_gnt) push_read(1'b0, p0_addr);
      if (p1_gnt) push_read(1'b1, p1_addr);
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_lock();
    p0_req = 1'b1; p0_lock = 1'b1; p0_addr = 16'h0600;
    @(negedge clock);
    checks++;
    if (p0_gnt !== 1'b1) begin
      errors++;
      $display("FAIL mid_lock_setup: p0_gnt=%b, required 1", p0_gnt);
    end
    step();
    reset = 1'b1;
    p0_req = 1'b0; p0_lock = 1'b0;
    p1_req = 1'b1; p1_addr = 16'h0700;
    @(negedge clock);
    checks++;
    if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0 || mem_en !== 1'b0 || p0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_lock_reset: gnt=%b%b mem_en=%b p0_rvalid=%b, required 00 0 0", p0_gnt, p1_gnt, mem_en, p0_rvalid);
    end
    step();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_gnt: gnt=%b%b, required 01", p0_gnt, p1_gnt);
    end
    if (p1_gnt) push_read(1'b1, p1_addr);
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_fixed_prio();
    reset = 1'b1;
    step();
    reset = 1'b0;
    p0_we = 1'b1; p1_we = 1'b1;
    for (int k = 0; k < 6; k++) begin
      p0_req   = (k < 5);
      p1_req   = 1'b1;
      p0_addr  = 16'hF000 + 16'(k);
      p1_addr  = 16'hF100 + 16'(k);
      p0_wdata = 8'h60 + 8'(k);
      p1_wdata = 8'h90 + 8'(k);
      @(negedge clock);
      checks++;
      if (fp_p0_gnt !== (k < 5) || fp_p1_gnt !== (k == 5) ||
          fp_mem_addr !== ((k < 5) ? p0_addr : p1_addr) ||
          fp_mem_wdata !== ((k < 5) ? p0_wdata : p1_wdata) || fp_mem_we !== 1'b1) begin
        errors++;
        $display("FAIL fixed_prio[%0d]: gnt=%b%b addr=%h wdata=%h we=%b, required %b%b",
                 k, fp_p0_gnt, fp_p1_gnt, fp_mem_addr, fp_mem_wdata, fp_mem_we, k < 5, k == 5);
      end
      step();
    end
    idle_inputs();
    step();
    p0_we = 1'b1; p1_we = 1'b1;
    for (int k = 0; k < 10; k++) begin
      p0_req  = 1'b1;
      p0_lock = (k < 9);
      p0_addr = 16'hF200 + 16'(k);
      p1_req  = (k >= 1);
      p1_addr = 16'hF300 + 16'(k);
      @(negedge clock);
      checks++;
      if (fp_p0_gnt !== (k != 8) || fp_p1_gnt !== (k == 8)) begin
        errors++;
        $display("FAIL fp_forced_release[%0d]: gnt=%b%b, required %b%b", k, fp_p0_gnt, fp_p1_gnt, k != 8, k == 8);
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
    end
    mem[16'h1234] = 8'hA5;

    test_reset();
    test_lone_read();
    test_write_read();
    test_round_robin();
    test_lock();
    test_forced_release();
    test_reset_mid_lock();
    test_fixed_prio();
    repeat (2) step();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb.size());
    end
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
